// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;
   localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

   // RUN issues new fetches; DRAIN waits for stale responses after a redirect.
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   // One prefetch FIFO entry: the instruction and the PC it was fetched from.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered storage, head driven straight from the array.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           rdata,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   assign rdata  = mem[rd_ptr];

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a prefetch FIFO,
// with branch redirect that flushes the FIFO and drops stale responses.
//
// Handshakes: IMEM_REQ/IMEM_ADDR are held until IMEM_GNT is seen in the same
// cycle (a transfer happens on a rising edge where both are high); responses
// come back in grant order. On the core side an instruction is consumed on a
// rising edge where INSTR_VALID and INSTR_READY are both high; INSTR_VALID
// does not depend on INSTR_READY.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic               REDIRECT,
   input  logic [ADDR_W-1:0]  REDIRECT_PC,
   output logic               IMEM_REQ,
   output logic [ADDR_W-1:0]  IMEM_ADDR,
   input  logic               IMEM_GNT,
   input  logic               IMEM_RVALID,
   input  logic [INSTR_W-1:0] IMEM_RDATA,
   output logic               INSTR_VALID,
   output logic [INSTR_W-1:0] INSTRUCTION,
   output logic [ADDR_W-1:0]  INSTR_PC,
   input  logic               INSTR_READY,
   output fetch_state_e       dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   fetch_state_e      state, state_n;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
   logic [ADDR_W-1:0] rsp_pc, rsp_pc_n;
   logic [ADDR_W-1:0] tgt_pc, tgt_pc_n;
   logic [CW-1:0]     outstanding, outstanding_n;
   logic [CW-1:0]     drain, drain_n;
   logic [CW-1:0]     count, count_n;
   logic              hold_stale, stale_n;
   logic              grant, stale_grant, push, pop, hold_n, req_n;
   fetch_entry_t      push_entry, head_entry;

   assign IMEM_ADDR   = fetch_pc;
   assign dbg_state   = state;
   assign push_entry  = '{pc: rsp_pc, instr: IMEM_RDATA};
   assign INSTRUCTION = head_entry.instr;
   assign INSTR_PC    = head_entry.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .push  (push),
      .pop   (pop),
      .flush (REDIRECT),
      .wdata (push_entry),
      .rdata (head_entry),
      .valid (INSTR_VALID),
      .count (count)
   );

   // Next-state: credit accounting, stale tracking and PC updates.
   always_comb begin
      grant       = IMEM_REQ && IMEM_GNT;
      // A request granted in a redirect cycle, or one that was already held
      // when a redirect arrived, fetched from the old path.
      stale_grant = grant && (hold_stale || REDIRECT);
      push        = IMEM_RVALID && !REDIRECT && (drain == '0);
      pop         = INSTR_VALID && INSTR_READY && !REDIRECT;
      hold_n      = IMEM_REQ && !IMEM_GNT;
      stale_n     = hold_n && (hold_stale || REDIRECT);

      outstanding_n = outstanding + CW'(grant) - CW'(IMEM_RVALID);
      if (REDIRECT) begin
         drain_n = outstanding_n;
      end else begin
         drain_n = drain - CW'(IMEM_RVALID && (drain != '0)) + CW'(stale_grant);
      end
      count_n = REDIRECT ? '0 : (count + CW'(push) - CW'(pop));

      // A held request keeps its address; the redirect target waits in tgt_pc.
      fetch_pc_n = fetch_pc;
      if (grant) begin
         if (stale_grant) begin
            fetch_pc_n = REDIRECT ? REDIRECT_PC : tgt_pc;
         end else begin
            fetch_pc_n = fetch_pc + PC_STEP;
         end
      end else if (REDIRECT && !hold_n) begin
         fetch_pc_n = REDIRECT_PC;
      end
      tgt_pc_n = REDIRECT ? REDIRECT_PC : tgt_pc;

      rsp_pc_n = rsp_pc;
      if (REDIRECT) begin
         rsp_pc_n = REDIRECT_PC;
      end else if (push) begin
         rsp_pc_n = rsp_pc + PC_STEP;
      end

      if (REDIRECT) begin
         state_n = ((drain_n != '0) || stale_n) ? DRAIN : RUN;
      end else if (state == DRAIN) begin
         state_n = ((drain_n == '0) && !stale_n) ? RUN : DRAIN;
      end else begin
         state_n = RUN;
      end

      // A new request rises only with a free FIFO slot for every fetch in flight.
      req_n = hold_n ||
              ((state_n == RUN) && (({1'b0, count_n} + {1'b0, outstanding_n}) < DEPTH_C));
   end

   // Fetch control FSM and its registered request output.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= RUN;
         IMEM_REQ    <= 1'b0;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         tgt_pc      <= RESET_PC;
         outstanding <= '0;
         drain       <= '0;
         hold_stale  <= 1'b0;
      end else begin
         state       <= state_n;
         IMEM_REQ    <= req_n;
         fetch_pc    <= fetch_pc_n;
         rsp_pc      <= rsp_pc_n;
         tgt_pc      <= tgt_pc_n;
         outstanding <= outstanding_n;
         drain       <= drain_n;
         hold_stale  <= stale_n;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a simple in-order memory model.
module tb_inst_fetch_unit;
   import fetch_pkg::*;

   logic               CLOCK       = 1'b0;
   logic               RESET_N     = 1'b0;
   logic               REDIRECT    = 1'b0;
   logic [ADDR_W-1:0]  REDIRECT_PC = '0;
   logic               IMEM_REQ;
   logic [ADDR_W-1:0]  IMEM_ADDR;
   logic               IMEM_GNT    = 1'b0;
   logic               IMEM_RVALID = 1'b0;
   logic [INSTR_W-1:0] IMEM_RDATA  = '0;
   logic               INSTR_VALID;
   logic [INSTR_W-1:0] INSTRUCTION;
   logic [ADDR_W-1:0]  INSTR_PC;
   logic               INSTR_READY = 1'b0;
   fetch_state_e       dbg_state;

   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   lat       = 1;
   logic gnt_en    = 1'b1;
   int   grant_cnt = 0;
   logic [ADDR_W-1:0] mq_addr[$];
   int                mq_due[$];

   inst_fetch_unit #(.DEPTH(4), .RESET_PC(64'h0)) dut (
      .CLOCK       (CLOCK),
      .RESET_N     (RESET_N),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_GNT    (IMEM_GNT),
      .IMEM_RVALID (IMEM_RVALID),
      .IMEM_RDATA  (IMEM_RDATA),
      .INSTR_VALID (INSTR_VALID),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_PC    (INSTR_PC),
      .INSTR_READY (INSTR_READY),
      .dbg_state   (dbg_state)
   );

   // Clock and reset
   always #5 CLOCK = ~CLOCK;

   // Memory model: grants when enabled, answers each grant lat cycles later
   // with 0xAA000000 + address. Driven on the falling edge.
   always @(negedge CLOCK) begin
      logic [ADDR_W-1:0] a;
      cyc = cyc + 1;
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = '0;
      if (!RESET_N) begin
         mq_addr.delete();
         mq_due.delete();
         IMEM_GNT = 1'b0;
      end else begin
         if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = 32'hAA00_0000 + a[31:0];
         end
         IMEM_GNT = IMEM_REQ && gnt_en;
         if (IMEM_GNT) begin
            mq_addr.push_back(IMEM_ADDR);
            mq_due.push_back(cyc + lat);
            grant_cnt = grant_cnt + 1;
         end
      end
   end

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   // Reset, configure memory and core, release; returns in the first cycle
   // after the first active edge out of reset.
   task automatic do_reset(input int l, input logic g, input logic rdy);
      RESET_N     = 1'b0;
      REDIRECT    = 1'b0;
      lat         = l;
      gnt_en      = g;
      INSTR_READY = rdy;
      tick;
      tick;
      RESET_N = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      RESET_N = 1'b0;
      tick;
      tick;
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", IMEM_REQ); end
      checks++; if (IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", IMEM_ADDR); end
      checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", INSTR_VALID); end
      checks++; if (INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", INSTRUCTION); end
      checks++; if (INSTR_PC !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", INSTR_PC); end
      checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, RUN); end
      RESET_N = 1'b1;
      tick;
      checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL first_req: got req=%0h addr=%0h expected req=1 addr=0", IMEM_REQ, IMEM_ADDR); end
   endtask

   task automatic test_stream;
      logic [ADDR_W-1:0] e;
      logic [INSTR_W-1:0] d;
      do_reset(1, 1'b1, 1'b1);
      tick;
      tick;
      for (int i = 0; i < 4; i++) begin
         e = 64'(4 * i);
         d = 32'hAA00_0000 + 32'(4 * i);
         checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== e) begin errors++; $display("FAIL stream_pc%0d: got valid=%0h pc=%0h expected valid=1 pc=%0h", i, INSTR_VALID, INSTR_PC, e); end
         checks++; if (INSTRUCTION !== d) begin errors++; $display("FAIL stream_instr%0d: got %0h expected %0h", i, INSTRUCTION, d); end
         tick;
      end
   endtask

   task automatic test_backpressure;
      int g0;
      logic [ADDR_W-1:0] e;
      do_reset(1, 1'b1, 1'b0);
      g0 = grant_cnt;
      for (int i = 0; i < 9; i++) tick;
      checks++; if (grant_cnt - g0 !== 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", grant_cnt - g0); end
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %0h expected 0", IMEM_REQ); end
      INSTR_READY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e = 64'(4 * i);
         checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== e) begin errors++; $display("FAIL bp_drain_pc%0d: got valid=%0h pc=%0h expected valid=1 pc=%0h", i, INSTR_VALID, INSTR_PC, e); end
         tick;
      end
   endtask

   task automatic test_redirect_drain;
      do_reset(3, 1'b1, 1'b1);
      tick;
      tick;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 64'h100;
      tick;
      REDIRECT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (dbg_state !== DRAIN || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin errors++; $display("FAIL drain_cycle%0d: got state=%0d req=%0h valid=%0h expected state=1 req=0 valid=0", i, dbg_state, IMEM_REQ, INSTR_VALID); end
         tick;
      end
      checks++; if (dbg_state !== RUN || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h100) begin errors++; $display("FAIL drain_resume: got state=%0d req=%0h addr=%0h expected state=0 req=1 addr=100", dbg_state, IMEM_REQ, IMEM_ADDR); end
      for (int i = 0; i < 4; i++) tick;
      checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 64'h100 || INSTRUCTION !== 32'hAA00_0100) begin errors++; $display("FAIL drain_first: got valid=%0h pc=%0h instr=%0h expected valid=1 pc=100 instr=aa000100", INSTR_VALID, INSTR_PC, INSTRUCTION); end
   endtask

   task automatic test_redirect_same_cycle;
      do_reset(1, 1'b1, 1'b1);
      tick;
      tick;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 64'h200;
      tick;
      REDIRECT = 1'b0;
      checks++; if (dbg_state !== DRAIN || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin errors++; $display("FAIL same_drop: got state=%0d req=%0h valid=%0h expected state=1 req=0 valid=0", dbg_state, IMEM_REQ, INSTR_VALID); end
      tick;
      checks++; if (dbg_state !== RUN || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h200) begin errors++; $display("FAIL same_resume: got state=%0d req=%0h addr=%0h expected state=0 req=1 addr=200", dbg_state, IMEM_REQ, IMEM_ADDR); end
      tick;
      tick;
      checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 64'h200 || INSTRUCTION !== 32'hAA00_0200) begin errors++; $display("FAIL same_first: got valid=%0h pc=%0h instr=%0h expected valid=1 pc=200 instr=aa000200", INSTR_VALID, INSTR_PC, INSTRUCTION); end
   endtask

   task automatic test_grant_stall;
      do_reset(1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL stall_hold%0d: got req=%0h addr=%0h expected req=1 addr=0", i, IMEM_REQ, IMEM_ADDR); end
         if (i < 4) tick;
      end
      gnt_en = 1'b1;
      tick;
      checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h4) begin errors++; $display("FAIL stall_advance: got req=%0h addr=%0h expected req=1 addr=4", IMEM_REQ, IMEM_ADDR); end
   endtask

   task automatic test_held_redirect;
      do_reset(1, 1'b0, 1'b1);
      tick;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 64'h300;
      tick;
      REDIRECT = 1'b0;
      checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0 || dbg_state !== DRAIN) begin errors++; $display("FAIL held_keep: got req=%0h addr=%0h state=%0d expected req=1 addr=0 state=1", IMEM_REQ, IMEM_ADDR, dbg_state); end
      gnt_en = 1'b1;
      tick;
      checks++; if (IMEM_REQ !== 1'b0 || dbg_state !== DRAIN) begin errors++; $display("FAIL held_drain: got req=%0h state=%0d expected req=0 state=1", IMEM_REQ, dbg_state); end
      tick;
      checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h300 || dbg_state !== RUN) begin errors++; $display("FAIL held_resume: got req=%0h addr=%0h state=%0d expected req=1 addr=300 state=0", IMEM_REQ, IMEM_ADDR, dbg_state); end
      tick;
      tick;
      checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 64'h300) begin errors++; $display("FAIL held_first: got valid=%0h pc=%0h expected valid=1 pc=300", INSTR_VALID, INSTR_PC); end
   endtask

   task automatic test_redirect_idle_wrap;
      logic [ADDR_W-1:0]  e;
      logic [INSTR_W-1:0] d;
      do_reset(1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick;
      REDIRECT    = 1'b1;
      REDIRECT_PC = 64'hFFFF_FFFF_FFFF_FFF8;
      tick;
      REDIRECT = 1'b0;
      checks++; if (dbg_state !== RUN || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'hFFFF_FFFF_FFFF_FFF8 || INSTR_VALID !== 1'b0) begin errors++; $display("FAIL idle_redirect: got state=%0d req=%0h addr=%0h valid=%0h expected state=0 req=1 addr=fffffffffffffff8 valid=0", dbg_state, IMEM_REQ, IMEM_ADDR, INSTR_VALID); end
      INSTR_READY = 1'b1;
      tick;
      tick;
      for (int i = 0; i < 4; i++) begin
         e = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i);
         d = 32'hAA00_0000 + e[31:0];
         checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== e || INSTRUCTION !== d) begin errors++; $display("FAIL wrap_pc%0d: got valid=%0h pc=%0h instr=%0h expected valid=1 pc=%0h instr=%0h", i, INSTR_VALID, INSTR_PC, INSTRUCTION, e, d); end
         tick;
      end
   endtask

   task automatic test_reset_midstream;
      do_reset(1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick;
      checks++; if (INSTR_VALID !== 1'b1 || IMEM_ADDR !== 64'h10) begin errors++; $display("FAIL mid_full: got valid=%0h addr=%0h expected valid=1 addr=10", INSTR_VALID, IMEM_ADDR); end
      RESET_N = 1'b0;
      #1;
      checks++; if (INSTR_VALID !== 1'b0 || IMEM_ADDR !== 64'h0 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL mid_reset: got valid=%0h addr=%0h req=%0h expected valid=0 addr=0 req=0", INSTR_VALID, IMEM_ADDR, IMEM_REQ); end
      tick;
      tick;
      RESET_N     = 1'b1;
      INSTR_READY = 1'b1;
      tick;
      checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h0) begin errors++; $display("FAIL mid_restart: got req=%0h addr=%0h expected req=1 addr=0", IMEM_REQ, IMEM_ADDR); end
      tick;
      tick;
      checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 64'h0) begin errors++; $display("FAIL mid_pc0: got valid=%0h pc=%0h expected valid=1 pc=0", INSTR_VALID, INSTR_PC); end
      tick;
      checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 64'h4) begin errors++; $display("FAIL mid_pc4: got valid=%0h pc=%0h expected valid=1 pc=4", INSTR_VALID, INSTR_PC); end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_backpressure;
      test_redirect_drain;
      test_redirect_same_cycle;
      test_grant_stall;
      test_held_redirect;
      test_redirect_idle_wrap;
      test_reset_midstream;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage placed directly upstream of the single-cycle LEGv8 core. Issues in-order requests to instruction memory over a request/grant/response interface and buffers returned 32-bit instructions with their PCs in a small prefetch FIFO. Delivers them to the core under a valid/ready handshake. A taken branch redirects the fetch PC, flushes the FIFO and discards stale in-flight responses.

## Interface
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 64'h0, fetch address after reset
- CLOCK  in  1  sole clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REDIRECT  in  1  core branch taken this cycle
- REDIRECT_PC  in  64  branch target, word aligned
- IMEM_REQ  out  1  fetch request valid
- IMEM_ADDR  out  64  fetch address; stable while IMEM_REQ && !IMEM_GNT
- IMEM_GNT  in  1  request accepted this cycle
- IMEM_RVALID  in  1  response valid; in order, ≥1 cycle after its grant
- IMEM_RDATA  in  32  response instruction
- INSTR_VALID  out  1  FIFO head valid
- INSTRUCTION  out  32  head instruction
- INSTR_PC  out  64  PC of head instruction
- INSTR_READY  in  1  core consumes head when INSTR_VALID && INSTR_READY

## Operation
- Registers: fetch_pc (next issue address), rsp_pc (PC of next accepted response), outstanding (0..DEPTH), drain (stale responses to drop), FIFO count.
- Credit rule: IMEM_REQ may newly rise only when count + outstanding < DEPTH; FIFO can never overflow.
- Grant: fetch_pc += 4, outstanding += 1. Response: outstanding -= 1; grant and response in same cycle leave outstanding unchanged.
- Response with drain == 0: push {rsp_pc, IMEM_RDATA}, rsp_pc += 4. Response with drain > 0: drop, drain -= 1.
- FSM states RUN, DRAIN.
  - RUN: issue per credit rule.
  - REDIRECT (any state): FIFO flushed, fetch_pc and rsp_pc ← REDIRECT_PC, drain ← outstanding after this cycle's grant/response (a grant in the redirect cycle counts as stale; a response in the redirect cycle is dropped). Next state DRAIN if drain ≠ 0, else RUN.
  - DRAIN: IMEM_REQ low; each response dropped; drain reaching 0 → RUN.
- A request asserted but not yet granted when REDIRECT arrives stays asserted with its old address until granted, then is counted as stale; the new target is issued afterwards.
- Pop and push in the same cycle on a full FIFO are legal (credit rule guarantees room).
- Address arithmetic modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 without fault.

## Timing
- Reset values: IMEM_REQ 0, IMEM_ADDR RESET_PC, INSTR_VALID 0, INSTRUCTION 0, INSTR_PC 0; fetch_pc = rsp_pc = RESET_PC, outstanding = drain = count = 0, state RUN.
- First IMEM_REQ in first cycle after RESET_N deasserts.
- IMEM_RVALID at cycle N → INSTR_VALID, INSTRUCTION, INSTR_PC visible from cycle N+1 (registered FIFO, head driven from storage).
- Throughput: one instruction per cycle with single-cycle memory and INSTR_READY held high.
- REDIRECT at cycle N → INSTR_VALID low at N+1; with no stale requests, IMEM_REQ with REDIRECT_PC at N+1.
- REDIRECT has priority over same-cycle pop.
- Reset mid-operation: all state cleared immediately; responses for pre-reset requests are the memory side's responsibility to suppress.

## Structure
- Shared package fetch_pkg: INSTR_W = 32, ADDR_W = 64, PC_STEP = 4, state enum {RUN, DRAIN}.
- One sub-module: fetch_fifo, synchronous FIFO (DEPTH × 96 bits, push/pop/flush, count output, async active-low reset).

## Test plan
- Reset then single-cycle memory returning 0xAA000000+addr, INSTR_READY = 1 → INSTR_PC 0,4,8,12 on consecutive cycles, one per cycle.
- INSTR_READY = 0 for 10 cycles, DEPTH = 4 → exactly 4 grants, IMEM_REQ stays low, FIFO holds PCs 0..12, nothing lost when READY returns.
- 3-cycle memory latency, 3 outstanding, REDIRECT to 0x100 → state DRAIN, 3 responses dropped, next INSTR_PC = 0x100.
- REDIRECT with response arriving same cycle and outstanding = 1 → that response dropped; next IMEM_ADDR = REDIRECT_PC after one more drop.
- IMEM_GNT held low 5 cycles → IMEM_ADDR stable at 0 throughout; grant then PC advances to 4.
- RESET_N pulsed low mid-stream with full FIFO → INSTR_VALID 0 and IMEM_ADDR = RESET_PC in same cycle, fetching restarts from RESET_PC.
